// File: rtl/grant_arbiter_rr4.sv
// Four-requester round-robin arbiter with grant hold and a hold-time limit.
// All outputs are registered so the downstream 2-to-4 decoder sees glitch-free select/enable.
module grant_arbiter_rr4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    // The hold counter is 5 bits, so the limit is compared after truncation.
    localparam logic [4:0] HOLD_LIM = 5'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [4:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;

    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       normal_rel;
    logic       contended;

    always_comb begin
        // Walk from the farthest offset back to ptr so the nearest set bit wins.
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) pick_idx = cand;
        end
    end

    assign normal_rel = done[grant_idx_q] || !req[grant_idx_q];
    assign contended  = |(req & ~(4'b0001 << grant_idx_q));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 5'd0;
                    ptr_d         = pick_idx + 2'd1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt_q != HOLD_LIM) hold_cnt_d = hold_cnt_q + 5'd1;
                if (normal_rel) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (hold_cnt_q == HOLD_LIM && contended) begin
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            hold_cnt_q    <= 5'd0;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
